times_table_writer: RTL and testbench
=====================================

Name: times_table_writer

Overview:
Populates the 64-entry 0..7 x 0..7 times-table memory through its write port, so the memory's read side can serve multiply lookups at address {a,b}. On a start pulse it steps through every address and computes a*b with a sequential shift-add multiplier. It then writes the product into the memory entry and reports busy/done. It is the write-side counterpart of the lookup multiplier and drives the same memory's clka/ena/wea/addra/dina pins.

Parameters:
A_WIDTH, 3, width of operand a (upper address field)
B_WIDTH, 3, width of operand b (lower address field); also the shift-add step count
(derived, not overridable) ADDR_WIDTH = DATA_WIDTH = A_WIDTH+B_WIDTH = 6

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request to (re)fill memory; sampled only in IDLE
busy  output  1  high while a fill is in progress
done  output  1  high after a complete fill; held until next accepted start or reset
ena  output  1  memory port enable; identical to wea
wea  output  1  memory write enable, one-cycle pulse per entry
addra  output  ADDR_WIDTH  write address = {a,b}
dina  output  DATA_WIDTH  write data = a*b

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-fill): state=IDLE; busy=0; done=0; wea=ena=0; addra=0; dina=0; internal index and accumulator=0.
- Reset does not clear memory contents; a partially written memory is left as is.
- States: IDLE, MULT, WRITE. The DONE condition is expressed by the done flag in IDLE.
- IDLE: at an edge with start=1, set busy=1, done=0, idx=0, acc=0, step=0, and go to MULT. start=0 stays in IDLE. start is ignored outside IDLE.
- MULT: a=idx[5:3], b=idx[2:0].
  - Each edge: if b[step]=1 then acc += a<<step; step++.
  - After B_WIDTH (3) edges, go to WRITE. At that transition register wea=ena=1, addra=idx, dina=final acc.
- WRITE: lasts one cycle.
  - At the next edge: wea=ena=0.
  - If idx=63: busy=0, done=1, go to IDLE.
  - Otherwise: idx++, acc=0, step=0, go to MULT.
- Timing, with E0 = the edge accepting start:
  - Entry n write is visible (wea=1) in the cycle after edge E(4n+3).
  - The first write follows E3; the last (n=63) follows E255.
  - busy falls and done rises at E256.
  - Fill duration is exactly 256 cycles; there are exactly 64 wea pulses, never back-to-back.
- Arithmetic: the product is at most 7*7=49 < 64, so there is no overflow. The accumulator is DATA_WIDTH bits and unsigned.
- addra/dina hold their last values while wea=0. Only cycles with wea=1 are meaningful.
- start held high continuously after completion: the block restarts on the first edge in IDLE, so done is high for exactly one cycle (the cycle after E256).
- start and rst asserted together: rst wins.

Test Plan:
- Reset: assert rst asynchronously between edges -> busy=done=wea=ena=0 and addra=dina=0 immediately, without waiting for a clock edge.
- Full fill: pulse start for 1 cycle, capture all writes with a memory model -> exactly 64 writes covering addresses 0..63 in order.
  - addr 0 -> 0; addr 6'o75 (a=7,b=5) -> 35; addr 6'o37 (a=3,b=7) -> 21; addr 63 -> 49.
  - Every entry equals a*b.
- Timing: relative to the start edge E0 -> first wea after E3, wea spacing of 4 cycles, busy high for 256 cycles, done rises at E256 and stays high with start=0.
- start while busy: pulse start at write 10 -> ignored; still 64 writes total, done at E256 of the original start.
- Reset mid-fill: assert rst after write 20 -> no further wea. A new start then refills from addr 0, and all 64 entries are correct at completion.
- Restart: after done=1, pulse start -> done clears at the accepting edge, busy=1, and a second identical 64-write fill follows.

Source files
------------

// File: rtl/times_table_if.sv
// Write-side bus of the times-table filler: start request, status flags and
// the memory write port (ena/wea/addra/dina).
interface times_table_if #(
  parameter int A_WIDTH = 3,
  parameter int B_WIDTH = 3
);
  localparam int DATA_WIDTH = A_WIDTH + B_WIDTH;

  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  ena;
  logic                  wea;
  logic [DATA_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;

  modport master (
    output start,
    input  busy, done, ena, wea, addra, dina
  );

  modport slave (
    input  start,
    output busy, done, ena, wea, addra, dina
  );
endinterface

// File: rtl/times_table_writer.sv
// Fills the 64-entry a*b lookup memory: each address {a,b} gets its product,
// computed by a B_WIDTH-step shift-add multiplier, then written in one cycle.
module times_table_writer #(
  parameter int A_WIDTH = 3,
  parameter int B_WIDTH = 3
) (
  input  logic          clk,
  input  logic          rst,
  times_table_if.slave  bus
);
  localparam int DW = A_WIDTH + B_WIDTH;
  localparam int SW = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(B_WIDTH - 1);
  localparam logic [DW-1:0] LAST_IDX  = {DW{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] idx_q, idx_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [SW-1:0] step_q, step_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wea_q, wea_d;
  logic [DW-1:0] addra_q, addra_d;
  logic [DW-1:0] dina_q, dina_d;

  logic [DW-1:0]      a_ext_s;
  logic [B_WIDTH-1:0] b_s;
  logic [DW-1:0]      acc_sum_s;

  assign a_ext_s   = {{B_WIDTH{1'b0}}, idx_q[DW-1:B_WIDTH]};
  assign b_s       = idx_q[B_WIDTH-1:0];
  assign acc_sum_s = acc_q + (b_s[step_q] ? (a_ext_s << step_q) : {DW{1'b0}});

  // State and registered outputs; reset leaves memory contents untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= {DW{1'b0}};
      acc_q   <= {DW{1'b0}};
      step_q  <= {SW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wea_q   <= 1'b0;
      addra_q <= {DW{1'b0}};
      dina_q  <= {DW{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wea_q   <= wea_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    step_d  = step_q;
    busy_d  = busy_q;
    done_d  = done_q;
    wea_d   = 1'b0;
    addra_d = addra_q;
    dina_d  = dina_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          busy_d  = 1'b1;
          done_d  = 1'b0;
          idx_d   = {DW{1'b0}};
          acc_d   = {DW{1'b0}};
          step_d  = {SW{1'b0}};
          state_d = MULT;
        end else begin
          state_d = IDLE;
        end
      end
      MULT: begin
        acc_d = acc_sum_s;
        if (step_q == LAST_STEP) begin
          // The write carries the product including this final partial term.
          step_d  = {SW{1'b0}};
          wea_d   = 1'b1;
          addra_d = idx_q;
          dina_d  = acc_sum_s;
          state_d = WRITE;
        end else begin
          step_d  = step_q + 1'b1;
          state_d = MULT;
        end
      end
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          acc_d   = {DW{1'b0}};
          step_d  = {SW{1'b0}};
          state_d = MULT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.wea   = wea_q;
  assign bus.ena   = wea_q;
  assign bus.addra = addra_q;
  assign bus.dina  = dina_q;
endmodule

// File: tb/tb_times_table_writer.sv
// Self-checking bench for times_table_writer: fill contents, write timing,
// start-while-busy, async reset (idle and mid-fill) and restart.
module tb_times_table_writer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  times_table_if #(.A_WIDTH(3), .B_WIDTH(3)) bus ();
  times_table_writer #(.A_WIDTH(3), .B_WIDTH(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int a;
    int b;
    int prod;
  } vec_t;
  vec_t vecs[12];

  int mem[64];
  int nwr, first_k, done_k;
  bit order_ok, spacing_ok, busy_ok, ena_ok, b2b_ok;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = -1;
  endtask

  // One start pulse, then watch the fill cycle by cycle (k = cycle after edge Ek).
  // inject_at >= 0 pulses start again right after write number inject_at.
  task automatic do_fill(input int inject_at);
    logic prev_wea;
    nwr = 0; first_k = -1; done_k = -1; prev_wea = 1'b0;
    order_ok = 1'b1; spacing_ok = 1'b1; busy_ok = 1'b1; ena_ok = 1'b1; b2b_ok = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("accept_busy", int'(bus.busy), 1);
    check("accept_done", int'(bus.done), 0);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.ena !== bus.wea) ena_ok = 1'b0;
      if (bus.wea === 1'b1) begin
        if (prev_wea) b2b_ok = 1'b0;
        if (int'(bus.addra) != nwr) order_ok = 1'b0;
        if (k != 4 * nwr + 3) spacing_ok = 1'b0;
        if (first_k < 0) first_k = k;
        mem[int'(bus.addra)] = int'(bus.dina);
        nwr++;
        if (nwr == inject_at + 1) bus.start = 1'b1;
      end
      prev_wea = bus.wea;
      if (bus.done === 1'b1) begin
        done_k = k;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    check("fill_terminated", int'(done_k >= 0), 1);
    check("write_count", nwr, 64);
    check("first_write_cycle", first_k, 3);
    check("done_cycle", done_k, 256);
    check("busy_low_at_done", int'(bus.busy), 0);
    check("addr_order", int'(order_ok), 1);
    check("wea_spacing", int'(spacing_ok), 1);
    check("busy_during_fill", int'(busy_ok), 1);
    check("ena_eq_wea", int'(ena_ok), 1);
    check("no_back_to_back", int'(b2b_ok), 1);
  endtask

  task automatic check_all_entries(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (mem[i] != (i / 8) * (i % 8)) bad++;
    end
    check({tag, "_bad_entries"}, bad, 0);
  endtask

  initial begin
    int n;
    int wcount;

    vecs[0]  = '{0, 0, 0};
    vecs[1]  = '{7, 5, 35};
    vecs[2]  = '{3, 7, 21};
    vecs[3]  = '{7, 7, 49};
    vecs[4]  = '{1, 1, 1};
    vecs[5]  = '{2, 3, 6};
    vecs[6]  = '{5, 6, 30};
    vecs[7]  = '{6, 4, 24};
    vecs[8]  = '{4, 0, 0};
    vecs[9]  = '{0, 7, 0};
    vecs[10] = '{7, 1, 7};
    vecs[11] = '{5, 5, 25};

    rst = 1'b1;
    bus.start = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_wea", int'(bus.wea), 0);
    check("rst_ena", int'(bus.ena), 0);
    check("rst_addra", int'(bus.addra), 0);
    check("rst_dina", int'(bus.dina), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(bus.busy), 0);

    // Fill 1: plain fill, table vectors and every entry.
    do_fill(-1);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("entry_%0dx%0d", vecs[i].a, vecs[i].b),
            mem[vecs[i].a * 8 + vecs[i].b], vecs[i].prod);
    end
    check_all_entries("fill1");
    repeat (5) @(negedge clk);
    check("done_held", int'(bus.done), 1);
    check("busy_idle_after", int'(bus.busy), 0);
    check("wea_idle_after", int'(bus.wea), 0);

    // Fill 2: restart from done, with a start pulse mid-fill that must be ignored.
    clear_mem();
    do_fill(10);
    check_all_entries("fill2");

    // Async reset between edges from the done state.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_done", int'(bus.done), 0);
    check("async_rst_addra", int'(bus.addra), 0);
    check("async_rst_dina", int'(bus.dina), 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-fill after write 20.
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    for (int k = 0; k < 200 && n < 21; k++) begin
      @(negedge clk);
      if (bus.wea === 1'b1) n++;
    end
    check("midfill_writes_seen", n, 21);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_wea", int'(bus.wea), 0);
    check("midrst_ena", int'(bus.ena), 0);
    check("midrst_addra", int'(bus.addra), 0);
    check("midrst_dina", int'(bus.dina), 0);
    @(negedge clk);
    rst = 1'b0;
    wcount = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.wea === 1'b1 || bus.busy === 1'b1) wcount++;
    end
    check("no_activity_after_rst", wcount, 0);

    // Refill after reset.
    clear_mem();
    do_fill(-1);
    check_all_entries("refill");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
